uart_receiver: RTL and testbench

Receive side of the board UART. Deserialises the `uart_rx` pin (8N1, LSB first) into bytes, buffers them in a small FIFO and exposes data and status to the Core as memory-mapped bytes alongside the existing `Led` and `Uart` transmit peripherals. The top level routes `mmio_rdata` onto the Core's data-read path whenever `mmio_hit` is high.

---
 rtl/uart_receiver_if.sv | 42 ++++
 rtl/uart_receiver.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Purpose: Core-side memory-mapped bus between the Core and the UART
//          receive peripheral, plus a read-only view of the receiver FSM.
//
// Signals:
//   mmio_addr   Core data address (16 bits)
//   mmio_data   Core write data (8 bits, carried but unused by the receiver)
//   mmio_update Core write strobe
//   mmio_rdata  read data for the addressed register, 8'h00 when not addressed
//   mmio_hit    address matches one of the receiver registers
//   rx_state    current receiver FSM state (debug visibility)
//
// Handshake: there is no valid/ready pair on this bus. A write is the single
// cycle in which mmio_update is high, and it takes effect at the next rising
// clock edge. Reads are combinational from mmio_addr and never stall.
interface uart_receiver_if;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_data;
    logic        mmio_update;
    logic [7:0]  mmio_rdata;
    logic        mmio_hit;
    logic [1:0]  rx_state;

    // Core side drives address/data/strobe.
    modport master (
        output mmio_addr,
        output mmio_data,
        output mmio_update,
        input  mmio_rdata,
        input  mmio_hit,
        input  rx_state
    );

    // Peripheral side answers reads and exposes its state.
    modport slave (
        input  mmio_addr,
        input  mmio_data,
        input  mmio_update,
        output mmio_rdata,
        output mmio_hit,
        output rx_state
    );
endinterface

// File: rtl/uart_receiver.sv
// Purpose: UART receive peripheral. Deserialises the rx pin (8N1, LSB first),
//          queues received bytes in a small FIFO and exposes data and status
//          as two memory-mapped bytes.
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous, active-low reset
//   rx        serial line, asynchronous to clock, idles high
//   rx_valid  FIFO not empty
//   bus       uart_receiver_if.slave: mmio_addr/mmio_data/mmio_update in,
//             mmio_rdata/mmio_hit/rx_state out
//
// Register map:
//   DATA_ADDR   read: FIFO head (8'h00 when empty); write: pop one entry
//   STATUS_ADDR read: {busy, count[2:0] (sat. at 7), frame_err, overrun,
//                      full, not_empty}; write: clear the sticky error bits
//
// DEPTH must be a power of two between 2 and 16.
module uart_receiver #(
    parameter int          CLK_FREQ    = 27000000,
    parameter int          BAUD        = 115200,
    parameter int          DEPTH       = 4,
    parameter logic [15:0] DATA_ADDR   = 16'hFF02,
    parameter logic [15:0] STATUS_ADDR = 16'hFF03
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rx,
    output logic            rx_valid,
    uart_receiver_if.slave  bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(DEPTH);
    localparam int PTR_W        = AW + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser: both stages reset to the idle (high) level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_req;
    logic             frame_evt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // The counter free-runs inside a state and is zeroed on every
    // transition, so each state measures time from its own entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_evt = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // Mid start bit: a line that is high again was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                // Leave for IDLE on the sampling cycle itself so a start bit
                // that follows the stop bit without a gap is still caught.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rxs_q) begin
                        push_req = 1'b1;
                    end else begin
                        frame_evt = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic hit_data;
    logic hit_status;
    logic wr_data;
    logic wr_status;

    assign hit_data   = (bus.mmio_addr == DATA_ADDR);
    assign hit_status = (bus.mmio_addr == STATUS_ADDR);
    assign wr_data    = bus.mmio_update && hit_data;
    assign wr_status  = bus.mmio_update && hit_status;

    // Write data is irrelevant: only the strobe and address carry meaning.
    logic unused_mmio_data;
    assign unused_mmio_data = ^bus.mmio_data;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             overrun_evt;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = wr_data && !fifo_empty;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    // When full, the write slot equals the head being popped this cycle.
    assign push_ok     = push_req && (!fifo_full || pop);
    assign overrun_evt = push_req && fifo_full && !pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = {1'b0, rd_ptr_q[AW-1:0] + AW'(1)};
        end
        if (push_ok) begin
            wr_ptr_d = {1'b0, wr_ptr_q[AW-1:0] + AW'(1)};
        end
        if (push_ok && !pop) begin
            count_d = count_q + PTR_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a new event in the clearing cycle wins.
    // ------------------------------------------------------------------
    logic overrun_q, overrun_d;
    logic frame_err_q, frame_err_d;

    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (wr_status) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end
        if (frame_evt) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational)
    // ------------------------------------------------------------------
    logic [7:0] head;
    logic [7:0] count_ext;
    logic [2:0] count_sat;
    logic [7:0] status;

    assign head      = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign count_ext = 8'(count_q);
    assign count_sat = (count_ext > 8'd7) ? 3'd7 : count_ext[2:0];
    assign status    = {(state_q != S_IDLE), count_sat, frame_err_q,
                        overrun_q, fifo_full, !fifo_empty};

    always_comb begin
        bus.mmio_rdata = 8'h00;
        if (hit_data) begin
            bus.mmio_rdata = head;
        end else if (hit_status) begin
            bus.mmio_rdata = status;
        end
    end

    assign bus.mmio_hit = hit_data || hit_status;
    assign bus.rx_state = state_q;
    assign rx_valid     = !fifo_empty;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int          CLK_FREQ    = 160;
    localparam int          BAUD        = 10;
    localparam int          DEPTH       = 4;
    localparam logic [15:0] DATA_ADDR   = 16'hFF02;
    localparam logic [15:0] STATUS_ADDR = 16'hFF03;
    localparam int          BIT_CYC     = CLK_FREQ / BAUD;   // 16
    localparam int          FRAME_CYC   = 10 * BIT_CYC;      // 160
    // Line cycle (counted from driving the start bit) whose closing edge is
    // the mid-stop-bit push: 2 sync + 1 start detect + half bit + 9 bits.
    localparam int          PUSH_EDGE   = 2 + 1 + BIT_CYC / 2 + 9 * BIT_CYC;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic rx;
    logic rx_valid;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .DEPTH       (DEPTH),
        .DATA_ADDR   (DATA_ADDR),
        .STATUS_ADDR (STATUS_ADDR)
    ) dut (
        .clock    (clk),
        .reset    (rst_n),
        .rx       (rx),
        .rx_valid (rx_valid),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_fe;
    logic       pop_pending;
    logic       chk_en;
    int         n_tests;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // A byte that completes while the FIFO is full is lost unless a pop
    // frees a slot in the same cycle.
    function automatic void model_push(input logic [7:0] d, input logic stop_ok);
        int occ;
        if (!stop_ok) begin
            exp_fe = 1'b1;
        end else begin
            occ = exp_q.size();
            if (pop_pending && occ > 0) occ = occ - 1;
            if (occ >= DEPTH) exp_ovr = 1'b1;
            else exp_q.push_back(d);
        end
    endfunction

    function automatic logic [7:0] model_rdata(input logic [15:0] a);
        int n;
        n = exp_q.size();
        if (a == DATA_ADDR) return (n > 0) ? exp_q[0] : 8'h00;
        if (a == STATUS_ADDR) begin
            return {1'b0, 3'((n > 7) ? 7 : n), exp_fe, exp_ovr,
                    (n == DEPTH), (n != 0)};
        end
        return 8'h00;
    endfunction

    // Busy (bit7 of status) is pinned by directed checks, not here.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
            check("mmio_hit", 32'(bus.mmio_hit),
                  32'((bus.mmio_addr == DATA_ADDR) || (bus.mmio_addr == STATUS_ADDR)));
            if (bus.mmio_addr == STATUS_ADDR)
                check("status_rd", 32'(bus.mmio_rdata & 8'h7F), 32'(model_rdata(bus.mmio_addr)));
            else
                check("rdata", 32'(bus.mmio_rdata), 32'(model_rdata(bus.mmio_addr)));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge. Drives ncyc cycles of an 8N1 frame.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int ncyc);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            rx = fr[c / BIT_CYC];
            @(posedge clk);
            #1;
            if (ncyc == FRAME_CYC && c + 1 == PUSH_EDGE) model_push(d, stop);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_data();
        bus.mmio_addr   = DATA_ADDR;
        bus.mmio_update = 1'b1;
        pop_pending     = 1'b1;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pop_pending     = 1'b0;
        bus.mmio_update = 1'b0;
    endtask

    task automatic write_status();
        bus.mmio_addr   = STATUS_ADDR;
        bus.mmio_update = 1'b1;
        @(posedge clk);
        #1;
        exp_ovr         = 1'b0;
        exp_fe          = 1'b0;
        bus.mmio_update = 1'b0;
    endtask

    task automatic write_other(input logic [15:0] a);
        bus.mmio_addr   = a;
        bus.mmio_update = 1'b1;
        bus.mmio_data   = 8'hEE;
        @(posedge clk);
        #1;
        bus.mmio_update = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] a, output logic [7:0] d);
        bus.mmio_addr = a;
        #1;
        d = bus.mmio_rdata;
    endtask

    task automatic expect_reg(input string name, input logic [15:0] a, input logic [7:0] e);
        logic [7:0] d;
        read_reg(a, d);
        check(name, 32'(d), 32'(e));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [7:0] rd;

    initial begin
        n_tests = 0;
        n_fail = 0;
        chk_en = 1'b0;
        exp_ovr = 1'b0;
        exp_fe = 1'b0;
        pop_pending = 1'b0;
        rst_n = 1'b0;
        rx = 1'b1;
        bus.mmio_addr = 16'h0000;
        bus.mmio_data = 8'h00;
        bus.mmio_update = 1'b0;

        // Reset state
        idle(3);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        expect_reg("reset_status", STATUS_ADDR, 8'h00);
        expect_reg("reset_data", DATA_ADDR, 8'h00);
        check("reset_hit", 32'(bus.mmio_hit), 32'd1);
        expect_reg("reset_other", 16'h1234, 8'h00);
        check("reset_other_hit", 32'(bus.mmio_hit), 32'd0);
        rst_n = 1'b1;
        idle(2);
        chk_en = 1'b1;

        // Single byte
        drive_frame(8'hA5, 1'b1, FRAME_CYC);
        idle(4);
        check("single_rx_valid", 32'(rx_valid), 32'd1);
        expect_reg("single_data", DATA_ADDR, 8'hA5);
        expect_reg("single_status", STATUS_ADDR, 8'h11);
        write_other(16'hFF01);
        check("other_hit", 32'(bus.mmio_hit), 32'd0);
        check("other_rdata", 32'(bus.mmio_rdata), 32'd0);
        check("other_no_pop", 32'(rx_valid), 32'd1);
        pop_data();
        idle(1);
        check("single_popped", 32'(rx_valid), 32'd0);
        expect_reg("single_empty", DATA_ADDR, 8'h00);

        // Back-to-back frames, no idle gap
        drive_frame(8'h00, 1'b1, FRAME_CYC);
        drive_frame(8'hFF, 1'b1, FRAME_CYC);
        drive_frame(8'h3C, 1'b1, FRAME_CYC);
        drive_frame(8'h81, 1'b1, FRAME_CYC);
        idle(4);
        expect_reg("b2b_status", STATUS_ADDR, 8'h43);

        // Overrun
        drive_frame(8'h55, 1'b1, FRAME_CYC);
        idle(4);
        expect_reg("ovr_status", STATUS_ADDR, 8'h47);
        expect_reg("ovr_head", DATA_ADDR, 8'h00);
        write_status();
        expect_reg("ovr_cleared", STATUS_ADDR, 8'h43);

        // Overrun avoided: pop lands on the push edge
        fork
            drive_frame(8'h99, 1'b1, FRAME_CYC);
            begin
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1;
                pop_data();
            end
        join
        idle(4);
        expect_reg("avoid_status", STATUS_ADDR, 8'h43);
        expect_reg("avoid_head0", DATA_ADDR, 8'hFF);
        pop_data();
        expect_reg("avoid_head1", DATA_ADDR, 8'h3C);
        pop_data();
        expect_reg("avoid_head2", DATA_ADDR, 8'h81);
        pop_data();
        expect_reg("avoid_tail", DATA_ADDR, 8'h99);
        pop_data();
        expect_reg("avoid_empty", STATUS_ADDR, 8'h00);
        expect_reg("avoid_empty_data", DATA_ADDR, 8'h00);

        // Framing error
        drive_frame(8'h12, 1'b0, FRAME_CYC);
        idle(20);
        expect_reg("frame_status", STATUS_ADDR, 8'h08);
        write_status();
        expect_reg("frame_cleared", STATUS_ADDR, 8'h00);

        // 4-cycle glitch
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        expect_reg("glitch_status", STATUS_ADDR, 8'h00);
        check("glitch_rx_valid", 32'(rx_valid), 32'd0);

        // Reset mid-frame with two bytes queued
        drive_frame(8'h11, 1'b1, FRAME_CYC);
        drive_frame(8'h22, 1'b1, FRAME_CYC);
        drive_frame(8'hC3, 1'b1, 70);
        expect_reg("pre_reset_status", STATUS_ADDR, 8'hA1);
        rst_n = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_fe = 1'b0;
        rx = 1'b1;
        #1;
        check("async_rx_valid", 32'(rx_valid), 32'd0);
        check("async_rdata", 32'(bus.mmio_rdata), 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        expect_reg("post_reset_status", STATUS_ADDR, 8'h00);
        drive_frame(8'h7E, 1'b1, FRAME_CYC);
        idle(4);
        expect_reg("post_reset_data", DATA_ADDR, 8'h7E);
        expect_reg("post_reset_st", STATUS_ADDR, 8'h11);
        pop_data();
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
